// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like downstream port between instruction fetch and data access.
// Data is serviced before inst; done flags hold results until the pipeline advances.
module sram_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_inst_en,
   input  logic [ADDR_W-1:0]   i_inst_addr,
   output logic [DATA_W-1:0]   o_inst_rdata,
   input  logic                i_data_en,
   input  logic [DATA_W/8-1:0] i_data_wen,
   input  logic [ADDR_W-1:0]   i_data_addr,
   input  logic [DATA_W-1:0]   i_data_wdata,
   output logic [DATA_W-1:0]   o_data_rdata,
   input  logic                i_advance,
   output logic                o_stallreq,
   output logic                o_m_req,
   output logic                o_m_wr,
   output logic [DATA_W/8-1:0] o_m_wstrb,
   output logic [ADDR_W-1:0]   o_m_addr,
   output logic [DATA_W-1:0]   o_m_wdata,
   input  logic                i_m_addr_ok,
   input  logic                i_m_data_ok,
   input  logic [DATA_W-1:0]   i_m_rdata
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_D_ADDR = 3'd1;
   localparam logic [2:0] S_D_DATA = 3'd2;
   localparam logic [2:0] S_I_ADDR = 3'd3;
   localparam logic [2:0] S_I_DATA = 3'd4;

   logic [2:0]          r_state;
   logic                r_inst_done;
   logic                r_data_done;
   logic                r_m_req;
   logic                r_m_wr;
   logic [DATA_W/8-1:0] r_m_wstrb;
   logic [ADDR_W-1:0]   r_m_addr;
   logic [DATA_W-1:0]   r_m_wdata;
   logic [DATA_W-1:0]   r_inst_rdata;
   logic [DATA_W-1:0]   r_data_rdata;

   logic w_inst_pend;
   logic w_data_pend;
   logic w_clear;
   logic w_complete;
   logic w_is_data;

   assign w_inst_pend = i_inst_en & ~r_inst_done;
   assign w_data_pend = i_data_en & ~r_data_done;
   assign o_stallreq  = w_inst_pend | w_data_pend;
   assign w_clear     = i_advance & ~o_stallreq;
   assign w_is_data   = (r_state == S_D_ADDR) || (r_state == S_D_DATA);

   // A same-cycle addr_ok+data_ok in an address phase completes the access outright.
   always_comb begin
      w_complete = 1'b0;
      case (r_state)
         S_D_ADDR, S_I_ADDR: w_complete = i_m_addr_ok & i_m_data_ok;
         S_D_DATA, S_I_DATA: w_complete = i_m_data_ok;
         default:            w_complete = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_m_req   <= 1'b0;
         r_m_wr    <= 1'b0;
         r_m_wstrb <= '0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_data_pend) begin
                  r_m_addr  <= i_data_addr;
                  r_m_wdata <= i_data_wdata;
                  r_m_wstrb <= i_data_wen;
                  r_m_wr    <= |i_data_wen;
                  r_m_req   <= 1'b1;
                  r_state   <= S_D_ADDR;
               end else if (w_inst_pend) begin
                  r_m_addr  <= i_inst_addr;
                  r_m_wstrb <= '0;
                  r_m_wr    <= 1'b0;
                  r_m_req   <= 1'b1;
                  r_state   <= S_I_ADDR;
               end
            end
            S_D_ADDR: begin
               if (i_m_addr_ok) begin
                  r_m_req <= 1'b0;
                  r_state <= i_m_data_ok ? S_IDLE : S_D_DATA;
               end
            end
            S_I_ADDR: begin
               if (i_m_addr_ok) begin
                  r_m_req <= 1'b0;
                  r_state <= i_m_data_ok ? S_IDLE : S_I_DATA;
               end
            end
            S_D_DATA, S_I_DATA: begin
               if (i_m_data_ok) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_m_req <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Clear beats set on the same edge; rdata is only written by a completing read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst_done  <= 1'b0;
         r_data_done  <= 1'b0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
      end else begin
         if (w_clear) begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
         end else if (w_complete) begin
            if (w_is_data) begin
               r_data_done <= 1'b1;
            end else begin
               r_inst_done <= 1'b1;
            end
         end
         if (w_complete && w_is_data && !r_m_wr) begin
            r_data_rdata <= i_m_rdata;
         end
         if (w_complete && !w_is_data) begin
            r_inst_rdata <= i_m_rdata;
         end
      end
   end

   assign o_m_req      = r_m_req;
   assign o_m_wr       = r_m_wr;
   assign o_m_wstrb    = r_m_wstrb;
   assign o_m_addr     = r_m_addr;
   assign o_m_wdata    = r_m_wdata;
   assign o_inst_rdata = r_inst_rdata;
   assign o_data_rdata = r_data_rdata;

endmodule
